pwm_setpoint_ramp: RTL
======================

# pwm_setpoint_ramp

Setpoint stage that sits between the I2C register interface and the PWM core. It assembles byte-wide register writes into a WIDTH-bit compare value and commits it atomically. The commit applies at a PWM period boundary, either as a single jump or as a slew-limited ramp of at most `step` counts per period, so the PWM never sees a torn or mid-period compare update.

## Interface
Parameters:
- `WIDTH`, 20: compare-value width; must satisfy 17 ≤ WIDTH ≤ 24.
- `REGBITS`, 3: register address width.
- `RESET_VALUE`, 20'hA0002: reset value of `cmp`, scratch and target.
- `STEP_DEFAULT`, 16'h0010: reset value of the step register.

Ports:
- `clk`  in  1  single clock, same domain as the PWM core.
- `rst_n`  in  1  asynchronous, active-low reset.
- `regAddr`  in  REGBITS  register address.
- `regData`  in  8  write data.
- `regDataValid`  in  1  one-cycle write strobe; address and data are valid while it is high.
- `period_start`  in  1  one-cycle pulse from the PWM core at each period boundary.
- `cmp`  out  WIDTH  compare value driven to the PWM core.
- `busy`  out  1  high while a commit is pending or a ramp is in progress.
- `overrun`  out  1  sticky flag: a commit overwrote an unapplied pending commit.

## Operation
Register map (write-only; addresses not listed are ignored):
- 0: `scratch[7:0]`.
- 1: `scratch[15:8]`.
- 2: `scratch[WIDTH-1:16]` takes `regData[WIDTH-17:0]`; upper data bits are ignored.
- 3: commit, data ignored. Sets `target` = `scratch`. Scratch is kept, so repeated commits are allowed.
- 4: `step[7:0]`.
- 5: `step[15:8]`.
- 6: control. bit0 = `ramp_en`; bit1 = write 1 to clear `overrun` (self-clearing, not stored).

State machine, states IDLE / PENDING / RAMP:
- IDLE: on commit -> PENDING.
- PENDING, on `period_start`:
  - `ramp_en`=0 or `step`=0: `cmp` <= `target`, go to IDLE.
  - Otherwise: apply one ramp step, go to RAMP. If the step reaches `target`, go to IDLE instead.
- RAMP, on each `period_start`: apply one ramp step; go to IDLE when `cmp` equals `target`.
- PENDING, on commit: overwrite `target`, set `overrun`, stay in PENDING.
- RAMP, on commit: overwrite `target`, no overrun; the ramp continues from the current `cmp` toward the new target.
- Clearing `ramp_en` during RAMP: the next `period_start` jumps straight to `target`.

Ramp step arithmetic:
- Unsigned; the difference is computed in WIDTH+1 bits.
- `step` is zero-extended to WIDTH.
- If |target − cmp| ≤ step, then `cmp` <= `target`. Otherwise `cmp` <= `cmp` ± `step`, moving toward `target`.
- No wrap-around is possible: `cmp` never overshoots `target` and never crosses 0 or 2^WIDTH−1.

Outputs:
- `busy` = (state ≠ IDLE), registered.
- `overrun`: a set and a clear in the same cycle resolve to set.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `cmp`, scratch, target = RESET_VALUE; `step` = STEP_DEFAULT.
  - `ramp_en`=0, `busy`=0, `overrun`=0, state IDLE.
- All outputs are registered.
- Writes take effect on the rising edge where `regDataValid`=1, and are visible the next cycle.
- Commit on cycle N: `busy`=1 from N+1.
- `cmp` updates on the edge that samples `period_start`=1, and is visible the next cycle.
- Commit and `period_start` in the same cycle:
  - `period_start` acts on the pre-commit state.
  - If the state was IDLE, the new target applies at the next `period_start`.
  - If the state was PENDING or RAMP, the old target is applied/stepped this cycle, then the new target is latched.
- `period_start` with no pending work: no change.
- Asserting `rst_n` mid-ramp returns all state to reset values immediately; no partial value persists.

## Test plan
- Reset -> `cmp`=20'hA0002, `busy`=0, `overrun`=0. Write 0x34/0x12/0x05 to addresses 0/1/2, then commit -> `cmp` unchanged and `busy`=1 until `period_start`; 1 cycle after it, `cmp`=20'h51234 and `busy`=0.
- `ramp_en`=1, `step`=0x1000, `cmp`=0x00000, commit target 0x02800 -> successive periods give 0x01000, 0x02000, 0x02800; `busy` falls after the third `period_start`.
- Downward ramp from 0x02800 to 0x00000 with `step`=0x1000 -> 0x01800, 0x00800, 0x00000; no underflow.
- Two commits with no `period_start` between them -> `overrun`=1 and the second target is applied. Write address 6 with data 0x02 -> `overrun`=0 while `ramp_en` stays 0.
- Commit in the same cycle as `period_start` from IDLE -> `cmp` unchanged at that boundary, updated at the next one.
- Deassert and reassert `rst_n` mid-ramp -> all outputs return to reset values asynchronously; a subsequent commit behaves as in the first scenario.

Source files
------------

// File: rtl/pwm_setpoint_ramp.sv
// pwm_setpoint_ramp
// Assembles byte-wide register writes into a WIDTH-bit compare value and
// hands it to the PWM core only at period boundaries, either as a single
// jump or as a slew-limited ramp of at most `step` counts per period.
module pwm_setpoint_ramp #(
   parameter int unsigned            WIDTH        = 20,
   parameter int unsigned            REGBITS      = 3,
   parameter logic [WIDTH-1:0]       RESET_VALUE  = 20'hA0002,
   parameter logic [15:0]            STEP_DEFAULT = 16'h0010
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [REGBITS-1:0] regAddr,
   input  logic [7:0]         regData,
   input  logic               regDataValid,
   input  logic               period_start,
   output logic [WIDTH-1:0]   cmp,
   output logic               busy,
   output logic               overrun
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_RAMP    = 2'd2
   } state_t;

   localparam logic [REGBITS-1:0] ADDR_SCR0   = REGBITS'(0);
   localparam logic [REGBITS-1:0] ADDR_SCR1   = REGBITS'(1);
   localparam logic [REGBITS-1:0] ADDR_SCR2   = REGBITS'(2);
   localparam logic [REGBITS-1:0] ADDR_COMMIT = REGBITS'(3);
   localparam logic [REGBITS-1:0] ADDR_STEP0  = REGBITS'(4);
   localparam logic [REGBITS-1:0] ADDR_STEP1  = REGBITS'(5);
   localparam logic [REGBITS-1:0] ADDR_CTRL   = REGBITS'(6);

   // One slew-limited move from cur toward tgt. The distance is formed in
   // WIDTH+1 bits and compared against step before any add/subtract, so the
   // result can never overshoot tgt or wrap past either end of the range.
   function automatic logic [WIDTH-1:0] ramp_step(
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] tgt,
      input logic [WIDTH-1:0] stp
   );
      logic [WIDTH:0]   diff;
      logic [WIDTH-1:0] res;
      if (tgt >= cur) begin
         diff = {1'b0, tgt} - {1'b0, cur};
         if (diff <= {1'b0, stp}) res = tgt;
         else                     res = cur + stp;
      end else begin
         diff = {1'b0, cur} - {1'b0, tgt};
         if (diff <= {1'b0, stp}) res = tgt;
         else                     res = cur - stp;
      end
      return res;
   endfunction

   state_t           state_q,   state_d;
   logic [WIDTH-1:0] cmp_q,     cmp_d;
   logic [WIDTH-1:0] scratch_q, scratch_d;
   logic [WIDTH-1:0] target_q,  target_d;
   logic [15:0]      step_q,    step_d;
   logic             ramp_en_q, ramp_en_d;
   logic             busy_q,    busy_d;
   logic             overrun_q, overrun_d;

   logic             commit_s;
   logic             ovr_clr_s;
   logic             ovr_set_s;
   logic             jump_s;
   logic [WIDTH-1:0] step_ext_s;
   logic [WIDTH-1:0] stepped_s;
   state_t           after_period_s;

   // Register-write decode: scratch bytes, step bytes, control, commit strobe.
   always_comb begin
      scratch_d = scratch_q;
      step_d    = step_q;
      ramp_en_d = ramp_en_q;
      commit_s  = 1'b0;
      ovr_clr_s = 1'b0;
      if (regDataValid) begin
         case (regAddr)
            ADDR_SCR0:   scratch_d[7:0]        = regData;
            ADDR_SCR1:   scratch_d[15:8]       = regData;
            ADDR_SCR2:   scratch_d[WIDTH-1:16] = regData[WIDTH-17:0];
            ADDR_COMMIT: commit_s              = 1'b1;
            ADDR_STEP0:  step_d[7:0]           = regData;
            ADDR_STEP1:  step_d[15:8]          = regData;
            ADDR_CTRL: begin
               ramp_en_d = regData[0];
               ovr_clr_s = regData[1];
            end
            default: scratch_d = scratch_q;
         endcase
      end else begin
         scratch_d = scratch_q;
      end
   end

   // Next-state / compare update. A period boundary always acts on the
   // pre-commit state; a commit in the same cycle is latched afterwards and
   // keeps the machine busy so the new target is not lost.
   always_comb begin
      state_d        = state_q;
      cmp_d          = cmp_q;
      target_d       = target_q;
      ovr_set_s      = 1'b0;
      after_period_s = state_q;
      step_ext_s     = {{(WIDTH-16){1'b0}}, step_q};
      stepped_s      = ramp_step(cmp_q, target_q, step_ext_s);
      jump_s         = (!ramp_en_q) || (step_q == 16'h0000);

      case (state_q)
         ST_IDLE: begin
            if (commit_s) state_d = ST_PENDING;
            else          state_d = ST_IDLE;
         end
         ST_PENDING, ST_RAMP: begin
            if (period_start) begin
               if (jump_s) begin
                  cmp_d          = target_q;
                  after_period_s = ST_IDLE;
               end else begin
                  cmp_d = stepped_s;
                  if (stepped_s == target_q) after_period_s = ST_IDLE;
                  else                       after_period_s = ST_RAMP;
               end
               if (commit_s && (after_period_s == ST_IDLE)) state_d = ST_PENDING;
               else                                          state_d = after_period_s;
            end else begin
               // An unapplied pending commit being replaced is the overrun case;
               // retargeting a ramp in flight is normal operation.
               if (commit_s && (state_q == ST_PENDING)) ovr_set_s = 1'b1;
               else                                      ovr_set_s = 1'b0;
               state_d = state_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (commit_s) target_d = scratch_q;
      else          target_d = target_q;

      busy_d    = (state_d != ST_IDLE);
      overrun_d = ovr_set_s | (overrun_q & ~ovr_clr_s);
   end

   // All state and outputs registered; reset restores every value at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cmp_q     <= RESET_VALUE;
         scratch_q <= RESET_VALUE;
         target_q  <= RESET_VALUE;
         step_q    <= STEP_DEFAULT;
         ramp_en_q <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmp_q     <= cmp_d;
         scratch_q <= scratch_d;
         target_q  <= target_d;
         step_q    <= step_d;
         ramp_en_q <= ramp_en_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign cmp     = cmp_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule
